// File: rtl/collision_detector.sv
// Frogger-style collision detector: registers per-lane player/car overlap,
// then a PLAY/HIT/GAME_OVER FSM counts lives and times invulnerability.
module collision_detector #(
    parameter int TILE_SIZE       = 32,
    parameter int C_LANE_BASE_ROW = 2,
    parameter int C_START_LIVES   = 3,
    parameter int C_INVULN_CYCLES = 12500000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [9:0] i_Car_X_0,
    input  logic [9:0] i_Car_X_1,
    input  logic [9:0] i_Car_X_2,
    input  logic [9:0] i_Car_X_3,
    input  logic [4:0] i_Player_X,
    input  logic [3:0] i_Player_Y,
    input  logic       i_Restart,
    output logic       o_Hit,
    output logic [1:0] o_Hit_Lane,
    output logic [3:0] o_Lives,
    output logic       o_Invulnerable,
    output logic       o_Game_Over
);

    typedef enum logic [1:0] {
        PLAY,
        HIT,
        GAME_OVER
    } state_e;

    localparam logic [10:0] TILE_W     = 11'(TILE_SIZE);
    localparam logic [3:0]  START_LIVE = 4'(C_START_LIVES);
    localparam logic [23:0] INV_LOAD   = 24'(C_INVULN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  flags_q, flags_d;
    logic [3:0]  lives_q, lives_d;
    logic [23:0] cnt_q, cnt_d;
    logic        hit_q, hit_d;
    logic [1:0]  lane_q, lane_d;

    logic [9:0]  px;
    logic [9:0]  car_x [4];
    logic [3:0]  overlap;
    logic [1:0]  low_lane;

    // 11-bit compares keep px+TILE and car+TILE from wrapping; touching edges fail '<'.
    always_comb begin
        car_x[0] = i_Car_X_0;
        car_x[1] = i_Car_X_1;
        car_x[2] = i_Car_X_2;
        car_x[3] = i_Car_X_3;
        px       = 10'(i_Player_X) * 10'(TILE_SIZE);
        overlap  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if ((i_Player_Y == 4'(C_LANE_BASE_ROW + k)) &&
                ({1'b0, car_x[k]} < ({1'b0, px} + TILE_W)) &&
                ({1'b0, px} < ({1'b0, car_x[k]} + TILE_W))) begin
                overlap[k] = 1'b1;
            end
        end
    end

    always_comb begin
        if (flags_q[0])      low_lane = 2'd0;
        else if (flags_q[1]) low_lane = 2'd1;
        else if (flags_q[2]) low_lane = 2'd2;
        else                 low_lane = 2'd3;
    end

    always_comb begin
        state_d = state_q;
        flags_d = overlap;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        lane_d  = lane_q;
        case (state_q)
            PLAY: begin
                if (|flags_q) begin
                    hit_d   = 1'b1;
                    lane_d  = low_lane;
                    lives_d = lives_q - 4'd1;
                    if (lives_q == 4'd1) begin
                        state_d = GAME_OVER;
                    end else begin
                        state_d = HIT;
                        cnt_d   = INV_LOAD;
                    end
                end
            end
            HIT: begin
                if (cnt_q == '0) state_d = PLAY;
                else             cnt_d   = cnt_q - 24'd1;
            end
            GAME_OVER: begin
                lives_d = '0;
                if (i_Restart) begin
                    state_d = PLAY;
                    lives_d = START_LIVE;
                    flags_d = '0;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= PLAY;
            flags_q <= '0;
            lives_q <= START_LIVE;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            lane_q  <= lane_d;
        end
    end

    assign o_Hit          = hit_q;
    assign o_Hit_Lane     = lane_q;
    assign o_Lives        = lives_q;
    assign o_Invulnerable = (state_q == HIT);
    assign o_Game_Over    = (state_q == GAME_OVER);

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector with a 4-cycle invulnerability window.
module tb_collision_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] car0, car1, car2, car3;
    logic [4:0] pxi;
    logic [3:0] pyi;
    logic       restart;
    logic       hit;
    logic [1:0] hit_lane;
    logic [3:0] lives;
    logic       inv;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    collision_detector #(
        .TILE_SIZE(32),
        .C_LANE_BASE_ROW(2),
        .C_START_LIVES(3),
        .C_INVULN_CYCLES(4)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Car_X_0(car0),
        .i_Car_X_1(car1),
        .i_Car_X_2(car2),
        .i_Car_X_3(car3),
        .i_Player_X(pxi),
        .i_Player_Y(pyi),
        .i_Restart(restart),
        .o_Hit(hit),
        .o_Hit_Lane(hit_lane),
        .o_Lives(lives),
        .o_Invulnerable(inv),
        .o_Game_Over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic clear_cars();
        car0 = 10'd600; car1 = 10'd600; car2 = 10'd600; car3 = 10'd600;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; pxi = '0; pyi = '0;
        clear_cars();
        step(2);
        check("rst_lives", lives, 3);
        check("rst_hit", hit, 0);
        check("rst_lane", hit_lane, 0);
        check("rst_inv", inv, 0);
        check("rst_go", game_over, 0);
        rst = 1'b0;

        // Basic hit in lane 1 and the 4-cycle invulnerable window
        pxi = 5'd5; pyi = 4'd3; car1 = 10'd140;
        step(1);
        check("s1_lat_nohit", hit, 0);
        step(1);
        check("s1_hit", hit, 1);
        check("s1_lane", hit_lane, 1);
        check("s1_lives", lives, 2);
        check("s1_inv0", inv, 1);
        car1 = 10'd600;
        for (int i = 1; i < 4; i++) begin
            step(1);
            check("s1_inv_on", inv, 1);
            check("s1_pulse", hit, 0);
        end
        step(1);
        check("s1_inv_off", inv, 0);
        check("s1_lives_hold", lives, 2);

        // Touching edges on either side, then one pixel of overlap
        car1 = 10'd128;
        step(2);
        check("s2_left_touch", hit, 0);
        car1 = 10'd192;
        step(1);
        check("s2_left_touch2", hit, 0);
        step(1);
        check("s2_right_touch", hit, 0);
        car1 = 10'd129;
        step(2);
        check("s2_overlap", hit, 1);
        check("s2_lives", lives, 1);
        clear_cars();
        step(4);
        do_reset();

        // Lane mapping by row, and an overlap held through HIT
        pxi = 5'd0; pyi = 4'd4; car2 = 10'd0; car3 = 10'd0;
        step(2);
        check("s3_hit", hit, 1);
        check("s3_lane2", hit_lane, 2);
        pyi = 4'd5;
        step(4);
        check("s3_back_play", inv, 0);
        check("s3_no_hit_yet", hit, 0);
        step(1);
        check("s3_hit_lane3", hit, 1);
        check("s3_lane3", hit_lane, 3);
        check("s3_lives", lives, 1);
        clear_cars();
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("s3_restart_ignored", lives, 1);
        check("s3_still_inv", inv, 1);

        // Continuous overlap from reset drains all lives
        pxi = 5'd5; pyi = 4'd3; car1 = 10'd160;
        rst = 1'b1;
        step(1);
        check("s4_rst_lives", lives, 3);
        rst = 1'b0;
        step(1);
        check("s4_lat", hit, 0);
        step(1);
        check("s4_hit1", hit, 1);
        check("s4_lives2", lives, 2);
        for (int h = 2; h <= 3; h++) begin
            for (int i = 0; i < 4; i++) begin
                step(1);
                check("s4_gap", hit, 0);
            end
            step(1);
            check("s4_hitn", hit, 1);
            check("s4_livesn", lives, 32'(3 - h));
        end
        check("s4_go", game_over, 1);
        check("s4_go_inv", inv, 0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("s4_go_nohit", hit, 0);
            check("s4_go_hold", game_over, 1);
            check("s4_go_lives", lives, 0);
        end

        // Restart together with overlap
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("s5_lives", lives, 3);
        check("s5_go", game_over, 0);
        check("s5_nohit", hit, 0);
        step(1);
        check("s5_nohit2", hit, 0);
        step(1);
        check("s5_hit", hit, 1);
        check("s5_lives2", lives, 2);

        // Reset during the second HIT cycle
        step(1);
        check("s6_in_hit", inv, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("s6_inv", inv, 0);
        check("s6_lives", lives, 3);
        check("s6_lane", hit_lane, 0);
        check("s6_go", game_over, 0);
        check("s6_nohit", hit, 0);
        step(1);
        check("s6_flags_cleared", hit, 0);
        step(1);
        check("s6_play_hit", hit, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
